// File: rtl/lc_state_decoder_pkg.sv
// Life-cycle state encodings, decoded indices and decoder FSM states.
// Shared by the decoder, its filter and the bus interface.
package lc_ctrl_state_pkg;

  localparam logic [1:0] B0 = 2'b01;
  localparam logic [1:0] B1 = 2'b10;

  typedef enum logic [3:0] {
    LcRaw   = {B0, B0},
    LcTest  = {B0, B1},
    LcProd  = {B1, B1},
    LcScrap = {B1, B0}
  } lc_state_e;

  typedef enum logic [1:0] {
    IdxRaw   = 2'd0,
    IdxTest  = 2'd1,
    IdxProd  = 2'd2,
    IdxScrap = 2'd3
  } lc_idx_e;

  typedef enum logic [1:0] {
    StIdle,
    StFilter,
    StStable,
    StError
  } dec_fsm_e;

  typedef enum logic [1:0] {
    ErrNone = 2'd0,
    ErrEnc  = 2'd1,
    ErrBack = 2'd2
  } err_code_e;

  function automatic logic lc_valid(logic [3:0] s);
    case (s)
      LcRaw, LcTest, LcProd, LcScrap: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic lc_idx_e lc_to_idx(logic [3:0] s);
    case (s)
      LcRaw:   return IdxRaw;
      LcTest:  return IdxTest;
      LcProd:  return IdxProd;
      default: return IdxScrap;
    endcase
  endfunction

endpackage

// File: rtl/lc_state_decoder_if.sv
// Sample/decoded-state bundle between lc state flops and consumers.
// err_code_o exists only with LC_STATE_DECODER_ERR_CODE_EN.
interface lc_state_decoder_if;

  logic [3:0] state_i;
  logic       state_valid_i;
  logic       dec_valid_o;
  logic [1:0] dec_state_o;
  logic [3:0] dec_onehot_o;
  logic       err_o;
  logic [3:0] trans_cnt_o;
`ifdef LC_STATE_DECODER_ERR_CODE_EN
  logic [1:0] err_code_o;

  modport master (
    output state_i, state_valid_i,
    input  dec_valid_o, dec_state_o, dec_onehot_o,
    input  err_o, trans_cnt_o, err_code_o
  );

  modport slave (
    input  state_i, state_valid_i,
    output dec_valid_o, dec_state_o, dec_onehot_o,
    output err_o, trans_cnt_o, err_code_o
  );
`else
  modport master (
    output state_i, state_valid_i,
    input  dec_valid_o, dec_state_o, dec_onehot_o,
    input  err_o, trans_cnt_o
  );

  modport slave (
    input  state_i, state_valid_i,
    output dec_valid_o, dec_state_o, dec_onehot_o,
    output err_o, trans_cnt_o
  );
`endif

endinterface

// File: rtl/lc_state_filter.sv
// Stability filter: candidate word plus run-length counter.
// Raises commit_o on the edge whose sample completes the run.
module lc_state_filter #(
  parameter int FilterCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       upd_i,
  input  logic       fresh_i,
  input  logic [3:0] sample_i,
  output logic       commit_o
);

  localparam int CntW = $clog2(FilterCycles + 1);

  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            match;

  assign match = !fresh_i && (sample_i == cand_q);

  // A fresh or differing sample restarts the run at one.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (upd_i) begin
      cand_d = sample_i;
      cnt_d  = match ? cnt_q + CntW'(1) : CntW'(1);
    end
  end

  assign commit_o = upd_i && (cnt_d == CntW'(FilterCycles));

  // Candidate and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lc_state_decoder.sv
// Life-cycle state reader: validate, filter, forward-only commit.
// Optional err_code_o under LC_STATE_DECODER_ERR_CODE_EN.
module lc_state_decoder
  import lc_ctrl_state_pkg::*;
#(
  parameter int FilterCycles = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  lc_state_decoder_if.slave bus
);

  dec_fsm_e   state_q, state_d;
  logic       valid_q, valid_d;
  lc_idx_e    idx_q, idx_d;
  logic [3:0] oh_q, oh_d;
  logic       err_q, err_d;
  logic [3:0] tcnt_q, tcnt_d;
  err_code_e  code_q, code_d;

  logic       sv, legal, upd, commit;
  lc_idx_e    idx;

  assign sv    = bus.state_valid_i;
  assign legal = lc_valid(bus.state_i);
  assign idx   = lc_to_idx(bus.state_i);

  assign upd = sv && legal && (state_q != StError) &&
               !(state_q == StStable && idx == idx_q);

  lc_state_filter #(
    .FilterCycles(FilterCycles)
  ) u_filter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .upd_i   (upd),
    .fresh_i (state_q != StFilter),
    .sample_i(bus.state_i),
    .commit_o(commit)
  );

  // Next state: error escalation, commit, or keep filtering.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    code_d  = code_q;
    if (state_q != StError && sv) begin
      if (!legal || (commit && valid_q && idx < idx_q)) begin
        state_d = StError;
        valid_d = 1'b1;
        idx_d   = IdxScrap;
        oh_d    = 4'b1000;
        err_d   = 1'b1;
        code_d  = legal ? ErrBack : ErrEnc;
      end else if (commit) begin
        state_d = StStable;
        valid_d = 1'b1;
        idx_d   = idx;
        oh_d    = 4'b0001 << idx;
        if (valid_q && idx != idx_q && tcnt_q != 4'hf)
          tcnt_d = tcnt_q + 4'd1;
      end else if (upd) begin
        state_d = StFilter;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      idx_q   <= IdxRaw;
      oh_q    <= 4'b0000;
      err_q   <= 1'b0;
      tcnt_q  <= 4'd0;
      code_q  <= ErrNone;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      code_q  <= code_d;
    end
  end

  assign bus.dec_valid_o  = valid_q;
  assign bus.dec_state_o  = idx_q;
  assign bus.dec_onehot_o = oh_q;
  assign bus.err_o        = err_q;
  assign bus.trans_cnt_o  = tcnt_q;
`ifdef LC_STATE_DECODER_ERR_CODE_EN
  assign bus.err_code_o   = code_q;
`else
  logic unused_code;
  assign unused_code = ^code_q;
`endif

endmodule

// File: tb/tb_lc_state_decoder.sv
// Bench for lc_state_decoder: vector tables through a scoreboard,
// async reset pulses and a FilterCycles=1 instance.
module tb_lc_state_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc_state_decoder_if b1();
  lc_state_decoder_if b2();

  lc_state_decoder #(.FilterCycles(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b1)
  );

  lc_state_decoder #(.FilterCycles(1)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b2)
  );

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       ev;
    logic [1:0] est;
    logic [3:0] eoh;
    logic       eerr;
    logic [3:0] ecnt;
    logic [1:0] ecode;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [3:0] a, logic [3:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic add(int n, logic v, logic [3:0] s, logic ev,
                     logic [1:0] est, logic [3:0] eoh, logic eerr,
                     logic [3:0] ecnt, logic [1:0] ecode);
    for (int i = 0; i < n; i++)
      tbl.push_back('{v, s, ev, est, eoh, eerr, ecnt, ecode});
  endtask

  task automatic cmp1(string nm, vec_t x);
    chk({nm, ".valid"}, 4'(b1.dec_valid_o), 4'(x.ev));
    chk({nm, ".state"}, 4'(b1.dec_state_o), 4'(x.est));
    chk({nm, ".onehot"}, b1.dec_onehot_o, x.eoh);
    chk({nm, ".err"}, 4'(b1.err_o), 4'(x.eerr));
    chk({nm, ".tcnt"}, b1.trans_cnt_o, x.ecnt);
`ifdef LC_STATE_DECODER_ERR_CODE_EN
    chk({nm, ".code"}, 4'(b1.err_code_o), 4'(x.ecode));
`endif
  endtask

  task automatic run_tbl(string tag);
    vec_t x;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      b1.state_valid_i = tbl[i].v;
      b1.state_i       = tbl[i].s;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      cmp1($sformatf("%s[%0d]", tag, i), x);
    end
    tbl.delete();
    @(negedge clk);
    b1.state_valid_i = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    vec_t z;
    z = '{1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 2'd0};
    cmp1(tag, z);
    chk({tag, ".b2valid"}, 4'(b2.dec_valid_o), 4'h0);
    chk({tag, ".b2err"}, 4'(b2.err_o), 4'h0);
  endtask

  task automatic pulse_rst(string tag);
    @(negedge clk);
    b1.state_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    b1.state_valid_i = 1'b0;
    b1.state_i       = 4'h0;
    b2.state_valid_i = 1'b0;
    b2.state_i       = 4'h0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Raw commit, Test with gaps, glitchy Prod, then invalid word.
    add(3, 1, 4'b0101, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b0101, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 0, 4'b0110, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 0, 4'b0111, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 0, 4'b0101, 1, 0, 4'b0001, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 1, 4'b0010, 0, 1, 0);
    add(2, 1, 4'b1010, 1, 1, 4'b0010, 0, 1, 0);
    add(1, 1, 4'b0110, 1, 1, 4'b0010, 0, 1, 0);
    add(3, 1, 4'b1010, 1, 1, 4'b0010, 0, 1, 0);
    add(1, 1, 4'b1010, 1, 2, 4'b0100, 0, 2, 0);
    add(1, 1, 4'b0111, 1, 3, 4'b1000, 1, 2, 1);
    add(1, 1, 4'b1010, 1, 3, 4'b1000, 1, 2, 1);
    add(1, 1, 4'b1001, 1, 3, 4'b1000, 1, 2, 1);
    run_tbl("main");
    pulse_rst("rst_in_err");

    // Reset mid-filter restarts the run; recommit same; reach Scrap.
    add(3, 1, 4'b0101, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b0101, 1, 0, 4'b0001, 0, 0, 0);
    add(2, 1, 4'b0110, 1, 0, 4'b0001, 0, 0, 0);
    run_tbl("pre_rst");
    pulse_rst("rst_in_filt");
    add(3, 1, 4'b0110, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 1, 4'b0010, 0, 0, 0);
    add(3, 1, 4'b1010, 1, 1, 4'b0010, 0, 0, 0);
    add(1, 1, 4'b1010, 1, 2, 4'b0100, 0, 1, 0);
    add(2, 1, 4'b1001, 1, 2, 4'b0100, 0, 1, 0);
    add(3, 1, 4'b1010, 1, 2, 4'b0100, 0, 1, 0);
    add(1, 1, 4'b1010, 1, 2, 4'b0100, 0, 1, 0);
    add(3, 1, 4'b1001, 1, 2, 4'b0100, 0, 1, 0);
    add(1, 1, 4'b1001, 1, 3, 4'b1000, 0, 2, 0);
    run_tbl("post_rst");
    pulse_rst("rst2");

    // Backward transition Prod -> Test escalates at the commit edge.
    add(3, 1, 4'b1010, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1010, 1, 2, 4'b0100, 0, 0, 0);
    add(3, 1, 4'b0110, 1, 2, 4'b0100, 0, 0, 0);
    add(1, 1, 4'b0110, 1, 3, 4'b1000, 1, 0, 2);
    add(4, 1, 4'b0101, 1, 3, 4'b1000, 1, 0, 2);
    run_tbl("backward");

    // FilterCycles=1 instance commits on the first valid sample.
    @(negedge clk);
    b2.state_valid_i = 1'b1;
    b2.state_i       = 4'b0110;
    @(posedge clk);
    #1;
    chk("fc1_a.valid", 4'(b2.dec_valid_o), 4'h1);
    chk("fc1_a.state", 4'(b2.dec_state_o), 4'h1);
    chk("fc1_a.tcnt", b2.trans_cnt_o, 4'h0);
    @(negedge clk);
    b2.state_i = 4'b1010;
    @(posedge clk);
    #1;
    chk("fc1_b.state", 4'(b2.dec_state_o), 4'h2);
    chk("fc1_b.onehot", b2.dec_onehot_o, 4'b0100);
    chk("fc1_b.tcnt", b2.trans_cnt_o, 4'h1);
    @(negedge clk);
    b2.state_i = 4'b0101;
    @(posedge clk);
    #1;
    chk("fc1_c.err", 4'(b2.err_o), 4'h1);
    chk("fc1_c.state", 4'(b2.dec_state_o), 4'h3);
    chk("fc1_c.tcnt", b2.trans_cnt_o, 4'h1);
    @(negedge clk);
    b2.state_valid_i = 1'b0;

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: %0d left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lc_state_decoder.md
Name: lc_state_decoder

Overview:
Reader side of the encoded life-cycle state register. Samples the 4-bit redundantly encoded state produced by the state flops. Validates each 2-bit word, filters for stability, enforces forward-only transitions, and presents a decoded index plus one-hot. Sits between the lc state flops and consumers of the life-cycle state; any corruption drives a terminal escalation to Scrap.

Parameters:
FilterCycles, 4, consecutive matching valid samples needed to commit a new state (legal range >= 1)
CntW, $clog2(FilterCycles+1), filter counter width (derived, not overridden)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
state_i  input  4  encoded state, two words {hi,lo}, each word must be B0=2'b01 or B1=2'b10
state_valid_i  input  1  state_i is sampled this cycle
dec_valid_o  output  1  dec_* outputs hold a committed state
dec_state_o  output  2  decoded index: Raw=0, Test=1, Prod=2, Scrap=3
dec_onehot_o  output  4  one-hot of dec_state_o
err_o  output  1  sticky fatal error
trans_cnt_o  output  4  count of committed state changes, saturating at 15

Behaviour:
- Interface: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- Encoding map: Raw={B0,B0}=4'b0101, Test={B0,B1}=4'b0110, Prod={B1,B1}=4'b1010, Scrap={B1,B0}=4'b1001.
- Any other value is invalid.
- Reset values: FSM Idle, dec_valid_o=0, dec_state_o=0, dec_onehot_o=4'b0000, err_o=0, trans_cnt_o=0, candidate=0, cnt=0.
- FSM states: Idle, Filter, Stable, Error.
- Cycles with state_valid_i=0 are ignored in every state; the counter holds and does not reset.
- Idle, valid sample:
  - Invalid sample -> Error.
  - Otherwise candidate<=state_i, cnt<=1, -> Filter.
  - With FilterCycles=1, commit on that same edge -> Stable.
- Filter, valid sample:
  - Invalid sample -> Error.
  - Sample == candidate: cnt++. When the incoming sample makes cnt reach FilterCycles, commit on that edge.
  - Sample != candidate: candidate<=state_i, cnt<=1.
- Commit:
  - Update dec_state_o and dec_onehot_o, set dec_valid_o=1, -> Stable.
  - trans_cnt_o increments (saturating) only when a previous committed state exists and differs from the new one.
  - If the new index < committed index (backward transition) -> Error instead of committing.
  - A committed-to-same value is not an error.
- Stable, valid sample:
  - Sample == committed: stay.
  - Valid sample != committed: candidate<=state_i, cnt<=1, -> Filter. Old committed value stays on the outputs with dec_valid_o=1 during filtering.
  - Invalid sample -> Error.
- Error (terminal until reset): err_o=1, dec_valid_o=1, dec_state_o=3, dec_onehot_o=4'b1000, trans_cnt_o frozen. Inputs are ignored.
- Latency: the first committed state is visible after the edge sampling the FilterCycles-th consecutive matching valid sample.
- Invalid-encoding detection has a single-edge latency.
- Reset asserted mid-filter or in Error returns all outputs to reset values immediately (asynchronous).
- No combinational path from inputs to outputs.

Optional Feature:
- Macro LC_STATE_DECODER_ERR_CODE_EN.
- When defined: extra output err_code_o [1:0] (0 none, 1 invalid encoding, 2 backward transition). It is set on entry to Error, held until reset, and resets to 0.
- When undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package lc_ctrl_state_pkg holds:
  - B0/B1 word constants
  - lc_state_e (all four encodings)
  - lc_idx_e (2-bit decoded index)
  - pure function for encoding validity and encoding->index
- No encodings may be duplicated in the decoder.
- Natural sub-module: lc_state_filter (candidate register, counter, match/commit strobe), parameterised by FilterCycles.

Test Plan:
- Reset then 4 valid cycles of 4'b0101 -> after 4th edge dec_valid_o=1, dec_state_o=0, dec_onehot_o=4'b0001, trans_cnt_o=0.
- Stable Raw, then 4 valid cycles of 4'b0110 interleaved with state_valid_i=0 gaps -> old Raw held during the gaps; commit Test (index 1) after 4th valid sample; trans_cnt_o=1.
- Filter glitch: Test stable, then 4'b1010 x2, 4'b0110 x1, 4'b1010 x4 -> no commit until the last run completes; then dec_state_o=2, trans_cnt_o=2.
- Invalid 4'b0111 in Stable Prod -> next edge err_o=1, dec_onehot_o=4'b1000; later legal inputs ignored; err_code_o=1 when macro defined.
- Backward: Prod committed, then 4'b0110 x4 -> Error at commit edge, dec_state_o=3, err_code_o=2.
- rst_ni pulsed low during Filter and during Error -> all outputs return to reset values without a clock edge; FilterCycles=1 build commits on the first valid sample.
